ieee_subtractor: RTL

IEEE_SUBTRACTOR -- requirements
Module: ieee_subtractor

---
 rtl/ieee_subtractor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ieee_subtractor.sv
// Multi-cycle IEEE-754 single-precision subtractor (ieee_1 - ieee_2) built as an ALIGN/OP/NORM state machine.
// Optional macro IEEE_SUBTRACTOR_ROUND_EN: round half-up on the guard bit instead of truncating.
module ieee_subtractor (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] ieee_1,
   input  logic [31:0] ieee_2,
   output logic [31:0] ieee_diff,
   output logic        state,
   output logic        done
);

   // Handshake: enable is a start request honoured only while state==0 (idle);
   // done pulses for one cycle when ieee_diff has just been loaded.
   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_OP, S_NORM, S_DONE} state_t;

   state_t      r_state;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_diff;
   logic [25:0] r_man_a;
   logic [25:0] r_man_b;
   logic [7:0]  r_d;
   logic [7:0]  r_exp;
   logic        r_sign;
   logic        r_sub;

   logic        w_a_ge;
   logic [30:0] w_big_mag;
   logic [30:0] w_small_mag;
   logic [7:0]  w_shift;
   logic        w_far;
   logic [23:0] w_frac_rnd;
   logic [8:0]  w_exp_rnd;
   logic [31:0] w_result;

   // Operand ordering by magnitude: exponent first, then fraction, which is plain unsigned order of bits [30:0].
   always_comb begin
      w_a_ge      = (ieee_1[30:0] >= ieee_2[30:0]);
      w_big_mag   = w_a_ge ? ieee_1[30:0] : ieee_2[30:0];
      w_small_mag = w_a_ge ? ieee_2[30:0] : ieee_1[30:0];
      w_shift     = w_big_mag[30:23] - w_small_mag[30:23];
      w_far       = (w_shift > 8'd25);
   end

   always_comb begin
`ifdef IEEE_SUBTRACTOR_ROUND_EN
      w_frac_rnd = {1'b0, r_man_a[23:1]} + {23'b0, r_man_a[0]};
`else
      w_frac_rnd = {1'b0, r_man_a[23:1]};
`endif
      w_exp_rnd = {1'b0, r_exp} + {8'b0, w_frac_rnd[23]};
      if (w_exp_rnd >= 9'd255) begin
         w_result = {r_sign, 8'hFF, 23'b0};
      end else begin
         w_result = {r_sign, w_exp_rnd[7:0], w_frac_rnd[22:0]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_diff  <= 32'h0;
         r_man_a <= 26'h0;
         r_man_b <= 26'h0;
         r_d     <= 8'h0;
         r_exp   <= 8'h0;
         r_sign  <= 1'b0;
         r_sub   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  r_man_a <= {2'b01, w_big_mag[22:0], 1'b0};
                  r_man_b <= w_far ? 26'h0 : {2'b01, w_small_mag[22:0], 1'b0};
                  r_d     <= w_far ? 8'h0 : w_shift;
                  r_exp   <= w_big_mag[30:23];
                  r_sub   <= (ieee_1[31] == ieee_2[31]);
                  r_sign  <= w_a_ge ? ieee_1[31] : ~ieee_2[31];
                  r_busy  <= 1'b1;
                  r_state <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (r_d != 8'h0) begin
                  r_man_b <= r_man_b >> 1;
                  r_d     <= r_d - 8'd1;
               end else begin
                  r_state <= S_OP;
               end
            end
            S_OP: begin
               r_man_a <= r_sub ? (r_man_a - r_man_b) : (r_man_a + r_man_b);
               r_state <= S_NORM;
            end
            S_NORM: begin
               // Exponent limits are tested after the shift that reached them, so each shift costs one cycle.
               if (r_man_a == 26'h0) begin
                  r_diff  <= 32'h0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_exp == 8'hFF) begin
                  r_diff  <= {r_sign, 8'hFF, 23'b0};
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_exp == 8'h00) begin
                  r_diff  <= {r_sign, 31'b0};
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_man_a[25]) begin
                  r_man_a <= r_man_a >> 1;
                  r_exp   <= r_exp + 8'd1;
               end else if (!r_man_a[24]) begin
                  r_man_a <= r_man_a << 1;
                  r_exp   <= r_exp - 8'd1;
               end else begin
                  r_diff  <= w_result;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ieee_diff = r_diff;
   assign state     = r_busy;
   assign done      = r_done;

endmodule
